// File: rtl/perf_counter_bank.sv
// Performance-monitor bank: NUM_CNT selectable event counters with snapshot shadows,
// registered readout, sequential clear sweep and halt freeze. Define PERF_SAT_EN to saturate instead of wrap.
module perf_counter_bank #(
  parameter int unsigned NUM_CNT = 8,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned EVT_W   = 8,
  parameter int unsigned SEL_W   = 3,
  parameter int unsigned ADDR_W  = 3
) (
  input  logic               clk,
  input  logic               RST,
  input  logic               halt,
  input  logic [EVT_W-1:0]   evt,
  input  logic               cfg_we,
  input  logic [ADDR_W-1:0]  cfg_addr,
  input  logic [SEL_W-1:0]   cfg_sel,
  input  logic               clr_all,
  input  logic               snap,
  input  logic               rd_en,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [CNT_W-1:0]   rd_data,
  output logic               rd_valid,
  output logic               busy,
  output logic [NUM_CNT-1:0] ovf
);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_HALTED = 2'd1;
  localparam logic [1:0] ST_CLEAR  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   cnt_q [NUM_CNT];
  logic [CNT_W-1:0]   cnt_d [NUM_CNT];
  logic [CNT_W-1:0]   shadow_q [NUM_CNT];
  logic [CNT_W-1:0]   shadow_d [NUM_CNT];
  logic [SEL_W-1:0]   sel_q [NUM_CNT];
  logic [SEL_W-1:0]   sel_d [NUM_CNT];
  logic [NUM_CNT-1:0] ovf_q, ovf_d;
  logic [CNT_W-1:0]   rd_data_q, rd_data_d;
  logic               rd_valid_q, rd_valid_d;
  logic [NUM_CNT-1:0] hit;
  logic               count_en;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    shadow_d   = shadow_q;
    sel_d      = sel_q;
    ovf_d      = ovf_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_en;
    hit        = '0;
    count_en   = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (clr_all) begin
          state_d = ST_CLEAR;
          idx_d   = '0;
        end else if (halt) begin
          state_d = ST_HALTED;
        end else begin
          count_en = 1'b1;
        end
      end
      ST_HALTED: begin
        if (clr_all) begin
          state_d = ST_CLEAR;
          idx_d   = '0;
        end else if (!halt) begin
          state_d = ST_RUN;
        end
      end
      ST_CLEAR: begin
        if (clr_all) begin
          idx_d = '0;
        end else if (idx_q == ADDR_W'(NUM_CNT - 1)) begin
          state_d = halt ? ST_HALTED : ST_RUN;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d = ST_RUN;
        idx_d   = '0;
      end
    endcase

    busy_d = (state_d == ST_CLEAR);

    // Selects out of event range never match, leaving that counter idle
    for (int unsigned i = 0; i < NUM_CNT; i++) begin
      for (int unsigned j = 0; j < EVT_W; j++) begin
        if (sel_q[i] == SEL_W'(j)) hit[i] = evt[j];
      end
    end

    for (int unsigned i = 0; i < NUM_CNT; i++) begin
      if (cfg_we && (cfg_addr == ADDR_W'(i))) sel_d[i] = cfg_sel;
      if ((state_q == ST_CLEAR) && (idx_q == ADDR_W'(i))) begin
        cnt_d[i] = '0;
        ovf_d[i] = 1'b0;
      end else if (count_en && hit[i]) begin
        if (cnt_q[i] == '1) begin
          ovf_d[i] = 1'b1;
`ifdef PERF_SAT_EN
          cnt_d[i] = cnt_q[i];
`else
          cnt_d[i] = '0;
`endif
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end

    if (snap) shadow_d = cnt_q;

    // Reads see the shadow as it was before any same-cycle snap
    if (rd_en) begin
      rd_data_d = '0;
      for (int unsigned i = 0; i < NUM_CNT; i++) begin
        if (rd_addr == ADDR_W'(i)) rd_data_d = shadow_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q    <= ST_RUN;
      idx_q      <= '0;
      busy_q     <= 1'b0;
      ovf_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_CNT; i++) begin
        cnt_q[i]    <= '0;
        shadow_q[i] <= '0;
        sel_q[i]    <= SEL_W'(i % EVT_W);
      end
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      busy_q     <= busy_d;
      ovf_q      <= ovf_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      for (int unsigned i = 0; i < NUM_CNT; i++) begin
        cnt_q[i]    <= cnt_d[i];
        shadow_q[i] <= shadow_d[i];
        sel_q[i]    <= sel_d[i];
      end
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign busy     = busy_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Scoreboarded bench for perf_counter_bank built with 4-bit counters so wrap/saturation is reachable.
module tb_perf_counter_bank;

  localparam int unsigned NUM_CNT = 8;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned EVT_W   = 8;
  localparam int unsigned SEL_W   = 3;
  localparam int unsigned ADDR_W  = 3;

  logic               clk = 1'b0;
  logic               RST;
  logic               halt;
  logic [EVT_W-1:0]   evt;
  logic               cfg_we;
  logic [ADDR_W-1:0]  cfg_addr;
  logic [SEL_W-1:0]   cfg_sel;
  logic               clr_all;
  logic               snap;
  logic               rd_en;
  logic [ADDR_W-1:0]  rd_addr;
  logic [CNT_W-1:0]   rd_data;
  logic               rd_valid;
  logic               busy;
  logic [NUM_CNT-1:0] ovf;

  typedef struct {
    string            name;
    logic [CNT_W-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  perf_counter_bank #(
    .NUM_CNT(NUM_CNT), .CNT_W(CNT_W), .EVT_W(EVT_W), .SEL_W(SEL_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .RST(RST), .halt(halt), .evt(evt), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_sel(cfg_sel), .clr_all(clr_all), .snap(snap), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one read; the monitor matches the returned data
  task automatic rd(input logic [ADDR_W-1:0] a, input logic [CNT_W-1:0] e, input string name);
    exp_t x;
    x.name = name;
    x.data = e;
    exp_q.push_back(x);
    rd_en   = 1'b1;
    rd_addr = a;
    tick();
    rd_en   = 1'b0;
  endtask

  task automatic do_snap();
    snap = 1'b1;
    tick();
    snap = 1'b0;
  endtask

  // Monitor: every rd_valid pulse must match the oldest outstanding read
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (rd_valid) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_rd_valid: got data %0h with no read pending", rd_data);
        end else begin
          x = exp_q.pop_front();
          check(x.name, 32'(rd_data), 32'(x.data));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int               nb;
    logic [CNT_W-1:0] wrap_exp;

    RST = 1'b0; halt = 1'b0; evt = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_sel = '0;
    clr_all = 1'b0; snap = 1'b0; rd_en = 1'b0; rd_addr = '0;
    repeat (3) tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_ovf", 32'(ovf), 0);
    check("rst_rd_valid", 32'(rd_valid), 0);
    check("rst_rd_data", 32'(rd_data), 0);
    RST = 1'b1;

    // Event 0 for ten cycles
    evt = 8'h01;
    repeat (10) tick();
    evt = '0;
    do_snap();
    for (int i = 1; i < 8; i++) rd(ADDR_W'(i), 4'd0, "t1_shadow_zero");
    rd(3'd0, 4'd10, "t1_shadow0");
    tick();
    check("t1_rd_valid_pulse", 32'(rd_valid), 0);
    check("t1_rd_data_hold", 32'(rd_data), 10);

    // Counter3 reselected to event 5, then halt freezes and HALTED costs one cycle
    cfg_we = 1'b1; cfg_addr = 3'd3; cfg_sel = 3'd5;
    tick();
    cfg_we = 1'b0;
    evt = 8'h20;
    repeat (4) tick();
    halt = 1'b1;
    repeat (2) tick();
    halt = 1'b0;
    tick();
    tick();
    evt = '0;
    do_snap();
    rd(3'd3, 4'd5, "t2_shadow3");
    rd(3'd5, 4'd5, "t2_shadow5");
    rd(3'd0, 4'd10, "t2_shadow0");

    // Reselect with event on the same cycle: old select counts now, new select after
    cfg_we = 1'b1; cfg_addr = 3'd1; cfg_sel = 3'd2; evt = 8'h02;
    tick();
    cfg_we = 1'b0; evt = 8'h04;
    tick();
    evt = 8'h02;
    tick();
    evt = '0;
    snap = 1'b1;
    rd(3'd1, 4'd0, "t5_snap_rd_same_cycle");
    snap = 1'b0;
    rd(3'd1, 4'd2, "t5_shadow1");
    rd(3'd2, 4'd1, "t5_shadow2");

    // Clear sweep with all events asserted
    clr_all = 1'b1; evt = 8'hFF;
    tick();
    clr_all = 1'b0;
    nb = 0;
    while (busy && nb < 20) begin
      nb++;
      tick();
    end
    evt = '0;
    check("t3_busy_cycles", 32'(nb), 8);
    check("t3_ovf_clear", 32'(ovf), 0);
    do_snap();
    for (int i = 0; i < 8; i++) rd(ADDR_W'(i), 4'd0, "t3_cleared");

    // 17 events on 4-bit counters 0 and 7
    evt = 8'h81;
    repeat (17) tick();
    evt = '0;
`ifdef PERF_SAT_EN
    wrap_exp = 4'd15;
`else
    wrap_exp = 4'd1;
`endif
    check("t4_ovf", 32'(ovf), 32'h81);
    do_snap();
    rd(3'd0, wrap_exp, "t4_cnt0");
    rd(3'd7, wrap_exp, "t4_cnt7");

    // Async reset when the sweep sits at idx 3
    clr_all = 1'b1;
    tick();
    clr_all = 1'b0;
    repeat (3) tick();
    check("t6_busy_mid_sweep", 32'(busy), 1);
    check("t6_ovf_mid_sweep", 32'(ovf), 32'h80);
    #2 RST = 1'b0;
    #1;
    check("t6_rst_busy", 32'(busy), 0);
    check("t6_rst_ovf", 32'(ovf), 0);
    check("t6_rst_rd_data", 32'(rd_data), 0);
    check("t6_rst_rd_valid", 32'(rd_valid), 0);
    tick();
    RST = 1'b1;
    evt = 8'h01;
    repeat (3) tick();
    evt = '0;
    check("t6_busy_after", 32'(busy), 0);
    do_snap();
    rd(3'd0, 4'd3, "t6_resume_cnt0");
    rd(3'd7, 4'd0, "t6_cnt7_reset");

    repeat (2) tick();
    check("sb_drain", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
